// File: rtl/vector_unpack.sv
// rtl/vector_unpack.sv - pops packed vectors from a FIFO and streams their elements one per handshake
module vector_unpack #(
    parameter int WIDTH    = 248,
    parameter int ELEM_W   = 31,
    parameter int NUM_ELEM = 8
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [WIDTH-1:0]              i_fifo_data,
    input  logic                          i_fifo_empty,
    output logic                          o_fifo_read,
    input  logic [$clog2(NUM_ELEM):0]     i_len,
    input  logic                          i_flush,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [ELEM_W-1:0]             o_elem,
    output logic                          o_last,
    output logic [15:0]                   o_vec_count
);

    localparam int LEN_W = $clog2(NUM_ELEM) + 1;
    localparam int IDX_W = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    idx_q, idx_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [WIDTH-1:0]    hold_q, hold_d;
    logic [15:0]         vec_count_q, vec_count_d;

    logic [ELEM_W-1:0]   elem_arr [NUM_ELEM];
    logic [LEN_W-1:0]    len_clamped;
    logic                last_elem;
    logic                fire;
    logic                pop;

    // Element 0 lives in the least significant slice of the held word
    for (genvar k = 0; k < NUM_ELEM; k++) begin : g_elem
        assign elem_arr[k] = hold_q[k*ELEM_W +: ELEM_W];
    end

    // A zero or oversized length means a full vector
    assign len_clamped = ((i_len == '0) || (i_len > LEN_W'(NUM_ELEM))) ? LEN_W'(NUM_ELEM) : i_len;

    assign o_valid     = (state_q == DRAIN);
    assign last_elem   = (idx_q == (len_q - LEN_W'(1)));
    assign o_last      = o_valid && last_elem;
    assign o_elem      = elem_arr[idx_q[IDX_W-1:0]];
    assign fire        = o_valid && i_ready;
    assign o_vec_count = vec_count_q;
    // Pop strobe is forced low while reset is held, even though the FSM already sits in IDLE
    assign o_fifo_read = pop && rstn;

    // Next-state: flush wins, otherwise load from IDLE or walk/reload while draining
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        len_d       = len_q;
        hold_d      = hold_q;
        vec_count_d = vec_count_q;
        pop         = 1'b0;

        if (i_flush) begin
            state_d = IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!i_fifo_empty) begin
                        pop     = 1'b1;
                        hold_d  = i_fifo_data;
                        len_d   = len_clamped;
                        idx_d   = '0;
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (fire) begin
                        if (!last_elem) begin
                            idx_d = idx_q + LEN_W'(1);
                        end else begin
                            vec_count_d = vec_count_q + 16'd1;
                            if (!i_fifo_empty) begin
                                // Reload on the final transfer so vectors run back to back
                                pop     = 1'b1;
                                hold_d  = i_fifo_data;
                                len_d   = len_clamped;
                                idx_d   = '0;
                                state_d = DRAIN;
                            end else begin
                                state_d = IDLE;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            len_q       <= LEN_W'(NUM_ELEM);
            hold_q      <= '0;
            vec_count_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            hold_q      <= hold_d;
            vec_count_q <= vec_count_d;
        end
    end

endmodule

// File: doc/vector_unpack.md
VECTOR_UNPACK -- requirements
Module: vector_unpack

Interface
REQ-001 SHALL have parameter WIDTH, default 248, giving the vector width in bits popped from the upstream vector FIFO.
REQ-002 SHALL have parameter ELEM_W, default 31, giving the element width in bits; WIDTH SHALL equal ELEM_W*NUM_ELEM.
REQ-003 SHALL have parameter NUM_ELEM, default 8, giving the elements per vector.
REQ-004 SHALL have port clk, input, 1, system clock, rising edge.
REQ-005 SHALL have port rstn, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port i_fifo_data, input, WIDTH, FIFO head word, valid combinationally whenever i_fifo_empty=0.
REQ-007 SHALL have port i_fifo_empty, input, 1, FIFO empty flag.
REQ-008 SHALL have port o_fifo_read, output, 1, FIFO pop strobe; one pop per cycle high.
REQ-009 SHALL have port i_len, input, $clog2(NUM_ELEM)+1, active element count for the next vector.
REQ-010 SHALL have port i_flush, input, 1, synchronous discard of the held vector.
REQ-011 SHALL have port o_valid, output, 1, element valid.
REQ-012 SHALL have port i_ready, input, 1, consumer ready.
REQ-013 SHALL have port o_elem, output, ELEM_W, current element.
REQ-014 SHALL have port o_last, output, 1, current element is the last of its vector.
REQ-015 SHALL have port o_vec_count, output, 16, count of fully drained vectors, wraps modulo 2^16.

Function
REQ-016 SHALL implement a two-state FSM, IDLE (no vector held) and DRAIN (vector held in a holding register).
REQ-017 SHALL drive o_fifo_read = 1 combinationally in IDLE when i_fifo_empty=0 and i_flush=0, capture i_fifo_data and latch the length on that edge, and enter DRAIN with element index 0.
REQ-018 SHALL latch the length as i_len, with i_len=0 or i_len>NUM_ELEM treated as NUM_ELEM.
REQ-019 SHALL assert o_valid = 1 exactly when the state is DRAIN.
REQ-020 SHALL drive o_elem from holding register bits [idx*ELEM_W +: ELEM_W], with element 0 at the LSBs.
REQ-021 SHALL drive o_last = 1 when idx equals the latched length minus 1; o_last is meaningful only while o_valid=1.
REQ-022 SHALL complete a transfer on a cycle with o_valid=1 and i_ready=1, and on that cycle increment idx when o_last=0.
REQ-023 SHALL hold o_elem, o_last and idx stable while o_valid=1 and i_ready=0.
REQ-024 SHALL handle a transfer with o_last=1 as follows:
  - increment o_vec_count;
  - if i_fifo_empty=0, assert o_fifo_read the same cycle, load the next vector and length, reset idx to 0 and stay in DRAIN, giving zero bubble between vectors;
  - otherwise go to IDLE.
REQ-025 SHALL give a latency of 1 cycle: a vector popped at edge N presents element 0 with o_valid=1 in the cycle after edge N.
REQ-026 SHALL never assert o_fifo_read while i_fifo_empty=1.
REQ-027 SHALL handle i_flush=1 in any state as follows:
  - enter IDLE on the next edge and discard the held vector;
  - keep o_fifo_read=0 that cycle;
  - leave o_vec_count unchanged;
  - i_flush takes priority over a simultaneous handshake.
REQ-028 SHALL ignore i_len except on cycles where o_fifo_read=1.

Reset
REQ-029 SHALL, while rstn=0, force state IDLE, idx=0, latched length=NUM_ELEM, holding register=0 and o_vec_count=0, giving outputs o_valid=0, o_fifo_read=0, o_last=0 and o_elem=0.
REQ-030 SHALL, on reset asserted mid-vector, lose the remaining elements and not pop on the first cycle after release unless i_fifo_empty=0.

Verification
REQ-031 Single vector: FIFO holds one word with element k = k+1, i_len=0, i_ready=1 -> one pop; elements 1..8 on 8 consecutive cycles, o_last on the 8th, o_vec_count=1, then IDLE.
REQ-032 Back-to-back: 3 vectors queued, i_ready=1 -> 24 consecutive valid cycles with no bubble, o_fifo_read pulses on cycles 0, 8 and 16, o_vec_count=3.
REQ-033 Backpressure: i_ready toggled 1,0,0,1 repeating -> o_elem/o_last held during the ready=0 cycles, no element dropped or duplicated, element order 0..7.
REQ-034 Short length: i_len=3 then i_len=12 -> first vector ends with o_last on element 2; second vector is clamped to 8 elements.
REQ-035 Flush: i_flush=1 asserted on element 4 together with i_ready=1 -> IDLE next cycle, no pop that cycle, o_vec_count unchanged, next vector starts at element 0.
REQ-036 Reset mid-drain: rstn=0 at element 5 -> all outputs 0 immediately (asynchronous); after release a queued vector is popped and starts at element 0.
